// File: rtl/cv32e40s_alert_rx.sv
// rtl/cv32e40s_alert_rx.sv - alert receiver: minor-alert counter and WARN/ESCALATE/LOCKED escalation FSM
// Optional leaky counter enabled by defining CV32E40S_ALERT_RX_LEAK_EN.
module cv32e40s_alert_rx #(
   parameter int MINOR_THRESHOLD = 4,
   parameter int CNT_WIDTH       = 8,
   parameter int ESC_DELAY       = 16,
   parameter int LEAK_PERIOD     = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 alert_minor_i,
   input  logic                 alert_major_i,
   input  logic                 clear_i,
   input  logic                 esc_ack_i,
   output logic                 irq_warn_o,
   output logic                 escalate_o,
   output logic                 locked_o,
   output logic [CNT_WIDTH-1:0] minor_cnt_o,
   output logic                 major_seen_o
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WARN     = 2'd1,
      ESCALATE = 2'd2,
      LOCKED   = 2'd3
   } state_t;

   localparam int TW = (ESC_DELAY > 1) ? $clog2(ESC_DELAY) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] THR     = CNT_WIDTH'(MINOR_THRESHOLD);
   localparam logic [TW-1:0]        T_LOAD  = TW'(ESC_DELAY - 1);

   state_t                r_state;
   state_t                w_state_next;
   logic [TW-1:0]         r_timer;
   logic [TW-1:0]         w_timer_next;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic [CNT_WIDTH-1:0]  w_cnt_next;
   logic                  r_minor_q;
   logic                  r_major_q;
   logic                  r_major_seen;
   logic                  w_clr_ok;
   logic                  w_inc;

   // clear only has effect while the handler is still recoverable
   assign w_clr_ok = clear_i && ((r_state == IDLE) || (r_state == WARN));
   assign w_inc    = r_minor_q && (r_cnt != CNT_MAX);

`ifdef CV32E40S_ALERT_RX_LEAK_EN
   localparam int LW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
   localparam logic [LW-1:0] LEAK_LAST = LW'(LEAK_PERIOD - 1);

   logic [LW-1:0] r_leak;
   logic          w_leak_dec;

   assign w_leak_dec = (r_leak == LEAK_LAST) && (r_cnt != '0) &&
                       ((r_state == IDLE) || (r_state == WARN));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_leak <= '0;
      end else if (w_clr_ok || (r_leak == LEAK_LAST)) begin
         r_leak <= '0;
      end else begin
         r_leak <= r_leak + 1'b1;
      end
   end

   always_comb begin
      w_cnt_next = r_cnt;
      if (w_clr_ok) begin
         w_cnt_next = {{(CNT_WIDTH-1){1'b0}}, r_minor_q};
      end else if (w_leak_dec) begin
         // a coincident minor event cancels the leak step
         w_cnt_next = r_minor_q ? r_cnt : r_cnt - 1'b1;
      end else if (w_inc) begin
         w_cnt_next = r_cnt + 1'b1;
      end
   end
`else
   always_comb begin
      w_cnt_next = r_cnt;
      if (w_clr_ok) begin
         w_cnt_next = {{(CNT_WIDTH-1){1'b0}}, r_minor_q};
      end else if (w_inc) begin
         w_cnt_next = r_cnt + 1'b1;
      end
   end
`endif

   always_comb begin
      w_state_next = r_state;
      w_timer_next = r_timer;
      case (r_state)
         IDLE: begin
            if (r_major_q) begin
               w_state_next = ESCALATE;
            end else if (clear_i) begin
               w_state_next = IDLE;
            end else if (w_cnt_next >= THR) begin
               w_state_next = WARN;
               w_timer_next = T_LOAD;
            end
         end
         WARN: begin
            if (r_major_q) begin
               w_state_next = ESCALATE;
            end else if (clear_i) begin
               w_state_next = IDLE;
            end else if (r_timer == '0) begin
               w_state_next = ESCALATE;
            end else begin
               w_timer_next = r_timer - 1'b1;
            end
         end
         ESCALATE: begin
            if (esc_ack_i) begin
               w_state_next = LOCKED;
            end
         end
         default: begin
            w_state_next = LOCKED;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_timer      <= '0;
         r_cnt        <= '0;
         r_minor_q    <= 1'b0;
         r_major_q    <= 1'b0;
         r_major_seen <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_timer      <= w_timer_next;
         r_cnt        <= w_cnt_next;
         r_minor_q    <= alert_minor_i;
         r_major_q    <= alert_major_i;
         r_major_seen <= r_major_seen | r_major_q;
      end
   end

   assign irq_warn_o   = (r_state == WARN);
   assign escalate_o   = (r_state == ESCALATE) || (r_state == LOCKED);
   assign locked_o     = (r_state == LOCKED);
   assign minor_cnt_o  = r_cnt;
   assign major_seen_o = r_major_seen;

endmodule
